// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU input conditioning stage.
//   - Default switch bus width and push-button count.
//   - Channel indices into the per-key debounce channel vector.
//   - Helper computing the debounce counter width from DB_COUNT.
package cpu_io_pkg;

  localparam int DEF_DW   = 8;
  localparam int DEF_NBTN = 3;

  localparam int CH_SAMPLE = 0;
  localparam int CH_BTN0   = 1;
  localparam int CH_BTN1   = 2;
  localparam int CH_BTN2   = 3;

  // The counter only ever reaches DB_COUNT-1, so clog2(DB_COUNT) bits suffice.
  // Clamped to 1 so a degenerate count still yields a legal vector.
  function automatic int cnt_width(input int db_count);
    int w;
    w = $clog2(db_count);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/cpu_input_stage_debounce_ch.sv
// debounce_ch: one key channel.
//   Two-flop synchroniser (s1, s2), then a debounce counter. The stable level
//   flips once s2 has differed from it for DB_COUNT consecutive edges; a
//   single-cycle press pulse accompanies each 0->1 flip.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   raw        : asynchronous key input, high = pressed
//   level      : debounced stable level (registered)
//   press      : one-cycle pulse on a debounced press (registered)
//   flip       : combinational, high when the stable level flips at the next
//                edge; lets the parent act on the same edge as the pulse
module debounce_ch
  import cpu_io_pkg::*;
#(
  parameter int DB_COUNT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic flip
);

  localparam int CW = cnt_width(DB_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  assign flip = (s2 != level) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= flip && !level;
      if (s2 == level) begin
        // Any return to the stable level restarts the count.
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_input_stage.sv
// cpu_input_stage: input conditioning directly upstream of the CPU core.
//   Synchronises the switches, Sample key and push buttons into the Clock
//   domain, debounces the keys, and captures the switch value on each
//   debounced Sample press.
// Ports:
//   Clock     : system clock, rising-edge
//   Reset     : synchronous active-high reset
//   DinRaw    : raw switch inputs (DW bits)
//   SampleRaw : raw Sample key, high = pressed
//   BtnsRaw   : raw push buttons (NBTN bits), high = pressed
//   Din       : switch value captured on the last Sample strobe
//   Sample    : one-cycle strobe on a debounced Sample press
//   Btns      : debounced button levels
//   BtnPress  : one-cycle pulse per button on a debounced press
module cpu_input_stage
  import cpu_io_pkg::*;
#(
  parameter int DB_COUNT = 16,
  parameter int DW       = DEF_DW,
  parameter int NBTN     = DEF_NBTN
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [DW-1:0]   DinRaw,
  input  logic            SampleRaw,
  input  logic [NBTN-1:0] BtnsRaw,
  output logic [DW-1:0]   Din,
  output logic            Sample,
  output logic [NBTN-1:0] Btns,
  output logic [NBTN-1:0] BtnPress
);

  localparam int NCH = 1 + NBTN;

  logic [NCH-1:0] key_raw;
  logic [NCH-1:0] key_level;
  logic [NCH-1:0] key_press;
  logic [NCH-1:0] key_flip;

  logic [DW-1:0]  din_s1;
  logic [DW-1:0]  din_s2;
  logic           capture;

  // Channel 0 is the Sample key, channels 1..NBTN the buttons.
  assign key_raw = {BtnsRaw, SampleRaw};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_ch #(
      .DB_COUNT(DB_COUNT)
    ) u_ch (
      .clk  (Clock),
      .reset(Reset),
      .raw  (key_raw[i]),
      .level(key_level[i]),
      .press(key_press[i]),
      .flip (key_flip[i])
    );
  end

  assign Sample   = key_press[CH_SAMPLE];
  assign Btns     = key_level[NCH-1:1];
  assign BtnPress = key_press[NCH-1:1];

  // Capture on the same edge that raises Sample so Din is valid in the strobe
  // cycle. The switch bits may skew through their synchronisers, but they have
  // been settled for DB_COUNT cycles by the time the Sample key qualifies.
  assign capture = key_flip[CH_SAMPLE] && !key_level[CH_SAMPLE];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      din_s1 <= '0;
      din_s2 <= '0;
      Din    <= '0;
    end else begin
      din_s1 <= DinRaw;
      din_s2 <= din_s1;
      if (capture) Din <= din_s2;
    end
  end

endmodule

// File: tb/tb_cpu_input_stage.sv
// Directed testbench for cpu_input_stage with DB_COUNT=4.
// Inputs are changed 1 time unit after a rising edge; outputs are sampled at
// the same point, so "cycle i after the change" means just after edge t0+i-1
// where t0 is the first edge sampling the new raw level. A press therefore
// shows up at i == 6 (just after edge t0+5).
module tb_cpu_input_stage;

  localparam int DB   = 4;
  localparam int DW   = 8;
  localparam int NBTN = 3;
  localparam int HIT  = DB + 2;

  logic            Clock;
  logic            Reset;
  logic [DW-1:0]   DinRaw;
  logic            SampleRaw;
  logic [NBTN-1:0] BtnsRaw;
  logic [DW-1:0]   Din;
  logic            Sample;
  logic [NBTN-1:0] Btns;
  logic [NBTN-1:0] BtnPress;

  int checks;
  int errors;

  cpu_input_stage #(
    .DB_COUNT(DB),
    .DW      (DW),
    .NBTN    (NBTN)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .DinRaw   (DinRaw),
    .SampleRaw(SampleRaw),
    .BtnsRaw  (BtnsRaw),
    .Din      (Din),
    .Sample   (Sample),
    .Btns     (Btns),
    .BtnPress (BtnPress)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    DinRaw    = 8'hFF;
    SampleRaw = 1'b1;
    BtnsRaw   = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Din !== 8'h00) begin errors++; $display("FAIL reset_din cyc%0d got %h exp 00", i, Din); end
      checks++;
      if (Sample !== 1'b0) begin errors++; $display("FAIL reset_sample cyc%0d got %b exp 0", i, Sample); end
      checks++;
      if (Btns !== 3'b000) begin errors++; $display("FAIL reset_btns cyc%0d got %b exp 000", i, Btns); end
      checks++;
      if (BtnPress !== 3'b000) begin errors++; $display("FAIL reset_press cyc%0d got %b exp 000", i, BtnPress); end
    end
    // Release reset with every key up so nothing qualifies afterwards.
    Reset     = 1'b0;
    DinRaw    = 8'hA5;
    SampleRaw = 1'b0;
    BtnsRaw   = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (Sample !== 1'b0 || BtnPress !== 3'b000 || Btns !== 3'b000) begin
        errors++;
        $display("FAIL idle cyc%0d got sample=%b press=%b btns=%b exp 0/000/000", i, Sample, BtnPress, Btns);
      end
    end
  endtask

  task automatic test_sample();
    logic exp_s;
    SampleRaw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_s = (i == HIT);
      checks++;
      if (Sample !== exp_s) begin errors++; $display("FAIL sample_strobe i=%0d got %b exp %b", i, Sample, exp_s); end
      if (i == 1) begin
        checks++;
        if (Din !== 8'h00) begin errors++; $display("FAIL sample_din_pre got %h exp 00", Din); end
      end
      if (i == HIT) begin
        checks++;
        if (Din !== 8'hA5) begin errors++; $display("FAIL sample_din got %h exp a5", Din); end
      end
    end
    DinRaw = 8'h3C;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (Din !== 8'hA5) begin errors++; $display("FAIL din_hold got %h exp a5", Din); end
    SampleRaw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (Sample !== 1'b0) begin errors++; $display("FAIL sample_release i=%0d got %b exp 0", i, Sample); end
    end
  endtask

  task automatic test_glitch();
    BtnsRaw = 3'b010;
    for (int i = 1; i <= 13; i++) begin
      if (i == 4) BtnsRaw = 3'b000;
      tick();
      checks++;
      if (Btns !== 3'b000 || BtnPress !== 3'b000) begin
        errors++;
        $display("FAIL glitch i=%0d got btns=%b press=%b exp 000/000", i, Btns, BtnPress);
      end
    end
  endtask

  task automatic test_bounce();
    logic [NBTN-1:0] exp_p;
    logic [NBTN-1:0] exp_b;
    BtnsRaw = 3'b010; tick();
    BtnsRaw = 3'b000; tick();
    checks++;
    if (BtnPress !== 3'b000) begin errors++; $display("FAIL bounce_early got %b exp 000", BtnPress); end
    BtnsRaw = 3'b010;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp_p = (i == HIT) ? 3'b010 : 3'b000;
      exp_b = (i >= HIT) ? 3'b010 : 3'b000;
      checks++;
      if (BtnPress !== exp_p) begin errors++; $display("FAIL bounce_press i=%0d got %b exp %b", i, BtnPress, exp_p); end
      checks++;
      if (Btns !== exp_b) begin errors++; $display("FAIL bounce_level i=%0d got %b exp %b", i, Btns, exp_b); end
    end
    BtnsRaw = 3'b000;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_b = (i >= HIT) ? 3'b000 : 3'b010;
      checks++;
      if (Btns !== exp_b) begin errors++; $display("FAIL release_level i=%0d got %b exp %b", i, Btns, exp_b); end
      checks++;
      if (BtnPress !== 3'b000) begin errors++; $display("FAIL release_press i=%0d got %b exp 000", i, BtnPress); end
    end
  endtask

  task automatic test_simultaneous();
    logic [NBTN-1:0] exp_p;
    logic [NBTN-1:0] exp_b;
    logic            exp_s;
    BtnsRaw   = 3'b101;
    SampleRaw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_p = (i == HIT) ? 3'b101 : 3'b000;
      exp_b = (i >= HIT) ? 3'b101 : 3'b000;
      exp_s = (i == HIT);
      checks++;
      if (BtnPress !== exp_p) begin errors++; $display("FAIL simul_press i=%0d got %b exp %b", i, BtnPress, exp_p); end
      checks++;
      if (Sample !== exp_s) begin errors++; $display("FAIL simul_sample i=%0d got %b exp %b", i, Sample, exp_s); end
      checks++;
      if (Btns !== exp_b) begin errors++; $display("FAIL simul_level i=%0d got %b exp %b", i, Btns, exp_b); end
      if (i == HIT) begin
        checks++;
        if (Din !== 8'h3C) begin errors++; $display("FAIL simul_din got %h exp 3c", Din); end
      end
    end
    BtnsRaw   = 3'b000;
    SampleRaw = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (Btns !== 3'b000) begin errors++; $display("FAIL simul_release got %b exp 000", Btns); end
  endtask

  task automatic test_reset_held();
    logic [NBTN-1:0] exp_p;
    BtnsRaw = 3'b001;
    // Four edges: s1, s2, then the counter reaches 2.
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (BtnPress !== 3'b000 || Btns !== 3'b000 || Sample !== 1'b0 || Din !== 8'h00) begin
        errors++;
        $display("FAIL held_reset cyc%0d got press=%b btns=%b sample=%b din=%h exp zeros", i, BtnPress, Btns, Sample, Din);
      end
    end
    Reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_p = (i == HIT) ? 3'b001 : 3'b000;
      checks++;
      if (BtnPress !== exp_p) begin errors++; $display("FAIL held_press i=%0d got %b exp %b", i, BtnPress, exp_p); end
    end
    checks++;
    if (Btns !== 3'b001) begin errors++; $display("FAIL held_level got %b exp 001", Btns); end
    BtnsRaw = 3'b000;
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sample();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_input_stage.md
Name: cpu_input_stage

Overview:
Input conditioning stage directly upstream of the CPU core. It synchronises the raw board switches (DinRaw), the Sample key and the three push buttons into the Clock domain and debounces the keys. It delivers a one-cycle Sample strobe with Din captured on that strobe, plus debounced button levels and one-cycle press pulses. Its outputs drive the CPU's Din, Sample and Btns inputs directly.

Parameters:
DB_COUNT, 16, number of consecutive cycles a synchronised key input must differ from its stable level before the stable level flips; legal range ≥2; use 4 in simulation.
DW, 8, width of the switch data bus.
NBTN, 3, number of push buttons.

Ports:
Clock  input  1  system clock; all state changes on its rising edge.
Reset  input  1  synchronous, active-high reset.
DinRaw  input  DW  raw asynchronous switch inputs.
SampleRaw  input  1  raw asynchronous Sample key, high = pressed.
BtnsRaw  input  NBTN  raw asynchronous push buttons, high = pressed.
Din  output  DW  switch value captured on the last Sample strobe (registered).
Sample  output  1  one-cycle strobe on a debounced Sample press (registered).
Btns  output  NBTN  debounced button levels (registered).
BtnPress  output  NBTN  one-cycle pulse per button on a debounced press (registered).

Behaviour:
- Reset (synchronous, sampled at the rising edge): clears all sync flops, counters and stable levels; Din=0, Sample=0, Btns=0, BtnPress=0. Reset has priority over every other event.
- Synchronisation: every raw input passes through two flops (s1, then s2). DinRaw uses the same two-flop chain per bit. Multi-bit skew is tolerated because Din is only captured after at least DB_COUNT stable cycles of the Sample key.
- Debounce, per key channel (Sample plus each button; 1+NBTN channels):
  - Counter width is clog2(DB_COUNT).
  - If s2 == stable: counter is cleared.
  - If s2 != stable and counter < DB_COUNT-1: counter increments.
  - If s2 != stable and counter == DB_COUNT-1: stable flips and counter clears.
- Latency: let t0 be the first edge that samples a new raw level into s1, with the raw level held. s2 changes at edge t0+1. Stable flips at edge t0+DB_COUNT+1. The pulse or level output is high in the cycle after that edge.
- Glitch rejection: any deviation shorter than DB_COUNT cycles at s2 clears the counter and leaves the outputs unchanged. A bounce restarts the count from its last transition.
- Press pulse: set at the same edge where stable flips 0→1, for exactly one cycle.
  - A release (stable 1→0) produces no pulse.
  - A held key produces exactly one pulse.
  - Btns mirrors the stable level of each button.
- Sample strobe: Sample is the Sample channel's press pulse. At that same edge, Din <= s2 of DinRaw. Din holds its value at all other times, including when DinRaw changes.
- Simultaneous events:
  - Channels are fully independent.
  - Several buttons qualifying on the same edge assert their BtnPress bits in the same cycle.
  - Sample and button pulses may coincide.
- Key held through reset: after reset deasserts, stable=0 and s2=1, so the key counts again and produces one press pulse. This is the required behaviour; with t0 = first edge where Reset is low, the pulse is high in the cycle after edge t0+DB_COUNT+1.

Decomposition:
- Shared package cpu_io_pkg:
  - DW=8 and NBTN=3 defaults.
  - Channel indices CH_SAMPLE=0, CH_BTN0=1, CH_BTN1=2, CH_BTN2=3.
  - Function computing the counter width from DB_COUNT.
- One sub-module, debounce_ch: a single channel with the two-flop sync, counter, stable level and rise pulse. Outputs: level, press. Instantiated 1+NBTN times.
- The top level adds the DinRaw synchroniser and the Din capture register.

Test Plan:
1. Hold Reset for 3 cycles with all raw inputs high -> Din=0x00, Sample=0, Btns=000, BtnPress=000 throughout reset.
2. DB_COUNT=4; DinRaw=0xA5 stable; SampleRaw rises at t0 and is held 20 cycles -> Sample high for exactly one cycle, after edge t0+5; Din=0xA5 in that cycle. Later DinRaw=0x3C -> Din stays 0xA5.
3. BtnsRaw[1] high for 3 cycles, then low -> Btns=000, BtnPress=000 for the whole run.
4. BtnsRaw[1] bounces 1,0,1 then is held high, with the last rise at t1 -> a single BtnPress=010 pulse after edge t1+5; Btns[1]=1 until release + 5 edges; no pulse on release.
5. BtnsRaw=101 rises on the same edge and SampleRaw rises on the same edge -> BtnPress=101 and Sample=1 in the same single cycle; Btns=101 afterwards.
6. BtnsRaw[0] held; Reset asserted while its counter=2, then deasserted (t0 = first low edge) -> outputs 0 during reset; BtnPress=001 exactly once, after edge t0+5.
